// File: rtl/l2_cache_pkg.sv
// Shared types and address-field width helpers for the L2 cache slice.
package l2_cache_pkg;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_WB     = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  function automatic int off_width(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int idx_width(input int cache_size, input int block_size, input int num_ways);
    return $clog2(cache_size / block_size / num_ways);
  endfunction

  function automatic int tag_width(input int addr_width, input int cache_size,
                                   input int block_size, input int num_ways);
    return addr_width - off_width(block_size) - idx_width(cache_size, block_size, num_ways);
  endfunction

endpackage

// File: rtl/l2_cache_if.sv
// Block handshake bundle seen by the L2: L1 request side plus main-memory side.
interface l2_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16
);
  localparam int LINE_W = BLOCK_SIZE * DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [LINE_W-1:0]     l1_data_in;
  logic [LINE_W-1:0]     l1_data_out;
  logic                  l1_read;
  logic                  l1_write;
  logic                  l1_ready;
  logic                  l1_hit;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_W-1:0]     mem_data_out;
  logic [LINE_W-1:0]     mem_data_in;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_ready;

  // The cache is the slave toward L1 and drives the memory-side requests.
  modport slave (
    input  l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    output l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );

  modport master (
    output l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    input  l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );
endinterface

// File: rtl/l2_victim_sel.sv
// Victim way choice: lowest-index invalid way, otherwise the set's round-robin pointer.
module l2_victim_sel #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = 2
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic [WAY_W-1:0]    victim
);

  logic found;

  always_comb begin
    victim = rr_ptr;
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_cache.sv
// Set-associative write-back, write-allocate L2 cache serving whole lines to L1.
// Optional saturating hit/miss/writeback counters when L2_PERF_CNT_EN is defined.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic clk,
  input  logic rst_n,
  l2_cache_if.slave bus
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
`endif
);

  localparam int OFF_W    = off_width(BLOCK_SIZE);
  localparam int IDX_W    = idx_width(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int TAG_W    = tag_width(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int NUM_SETS = 1 << IDX_W;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int LINE_W   = BLOCK_SIZE * DATA_WIDTH;

  logic [TAG_W-1:0]    tag_mem   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   data_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_mem [NUM_SETS];
  logic [WAY_W-1:0]    rr_ptr    [NUM_SETS];

  logic [2:0]        state;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  op_e               req_op;
  logic [LINE_W-1:0] req_data;
  logic [WAY_W-1:0]  vict_way;
  logic              vict_valid;

  logic              is_read;
  logic              lookup_hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  sel_way;
  logic              sel_valid;
  logic              sel_dirty;
  logic              wr_en;
  logic [WAY_W-1:0]  wr_way;
  logic [LINE_W-1:0] wr_line;
  logic              wr_dirty;
  logic              wr_bump;
  logic              unused_off;

  assign unused_off = ^bus.l1_addr[OFF_W-1:0];
  assign is_read    = (req_op == OP_READ);
  assign sel_valid  = valid_mem[req_idx][sel_way];
  assign sel_dirty  = dirty_mem[req_idx][sel_way];

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!lookup_hit && valid_mem[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  l2_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim_sel (
    .valid  (valid_mem[req_idx]),
    .rr_ptr (rr_ptr[req_idx]),
    .victim (sel_way)
  );

  // Every line install funnels through here; wr_bump marks replacement of a valid line.
  always_comb begin
    wr_en    = 1'b0;
    wr_way   = sel_way;
    wr_line  = req_data;
    wr_dirty = 1'b1;
    wr_bump  = 1'b0;
    case (state)
      ST_LOOKUP: begin
        if (lookup_hit) begin
          if (!is_read) begin
            wr_en  = 1'b1;
            wr_way = hit_way;
          end
        end else if (!is_read && !(sel_valid && sel_dirty)) begin
          wr_en   = 1'b1;
          wr_way  = sel_way;
          wr_bump = sel_valid;
        end
      end
      ST_WB: begin
        if (bus.mem_ready && !is_read) begin
          wr_en   = 1'b1;
          wr_way  = vict_way;
          wr_bump = vict_valid;
        end
      end
      ST_FILL: begin
        if (bus.mem_ready) begin
          wr_en    = 1'b1;
          wr_way   = vict_way;
          wr_line  = bus.mem_data_in;
          wr_dirty = 1'b0;
          wr_bump  = vict_valid;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[req_idx][wr_way]  <= req_tag;
      data_mem[req_idx][wr_way] <= wr_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      req_tag          <= '0;
      req_idx          <= '0;
      req_op           <= OP_READ;
      req_data         <= '0;
      vict_way         <= '0;
      vict_valid       <= 1'b0;
      bus.l1_data_out  <= '0;
      bus.l1_ready     <= 1'b0;
      bus.l1_hit       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_data_out <= '0;
      bus.mem_read     <= 1'b0;
      bus.mem_write    <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        rr_ptr[s]    <= '0;
      end
    end else begin
      if (wr_en) begin
        valid_mem[req_idx][wr_way] <= 1'b1;
        dirty_mem[req_idx][wr_way] <= wr_dirty;
        if (wr_bump)
          rr_ptr[req_idx] <= (rr_ptr[req_idx] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                      : rr_ptr[req_idx] + WAY_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (bus.l1_read || bus.l1_write) begin
            req_tag  <= bus.l1_addr[ADDR_WIDTH-1 -: TAG_W];
            req_idx  <= bus.l1_addr[OFF_W +: IDX_W];
            req_op   <= bus.l1_read ? OP_READ : OP_WRITE;
            req_data <= bus.l1_data_in;
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            bus.l1_hit   <= 1'b1;
            bus.l1_ready <= 1'b1;
            if (is_read)
              bus.l1_data_out <= data_mem[req_idx][hit_way];
            state <= ST_DONE;
          end else begin
            bus.l1_hit <= 1'b0;
            vict_way   <= sel_way;
            vict_valid <= sel_valid;
            if (sel_valid && sel_dirty) begin
              bus.mem_write    <= 1'b1;
              bus.mem_addr     <= {tag_mem[req_idx][sel_way], req_idx, {OFF_W{1'b0}}};
              bus.mem_data_out <= data_mem[req_idx][sel_way];
              state            <= ST_WB;
            end else if (is_read) begin
              bus.mem_read <= 1'b1;
              bus.mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state        <= ST_FILL;
            end else begin
              bus.l1_ready <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end
        ST_WB: begin
          if (bus.mem_ready) begin
            bus.mem_write <= 1'b0;
            if (is_read) begin
              bus.mem_read <= 1'b1;
              bus.mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
              state        <= ST_FILL;
            end else begin
              bus.l1_ready <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end
        ST_FILL: begin
          if (bus.mem_ready) begin
            bus.mem_read    <= 1'b0;
            bus.l1_data_out <= bus.mem_data_in;
            bus.l1_ready    <= 1'b1;
            state           <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.l1_ready <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef L2_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == ST_LOOKUP && lookup_hit && hit_cnt != '1)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == ST_LOOKUP && !lookup_hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 32'd1;
      if (state == ST_WB && bus.mem_ready && wb_cnt != '1)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Self-checking bench for l2_cache against a line-level cache/memory reference model.
// Build with L2_PERF_CNT_EN defined to also check the performance counters.
module tb_l2_cache;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BS    = 16;
  localparam int CS    = 4096;
  localparam int NW    = 4;
  localparam int LW    = DW * BS;
  localparam int NSETS = CS / BS / NW;
  localparam int OFFW  = $clog2(BS);
  localparam int IDXW  = $clog2(NSETS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  l2_cache #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_SIZE(CS), .BLOCK_SIZE(BS), .NUM_WAYS(NW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: per-set way contents plus a sparse backing memory keyed by line address.
  bit          m_valid [NSETS][NW];
  bit          m_dirty [NSETS][NW];
  logic [31:0] m_tag   [NSETS][NW];
  logic [LW-1:0] m_data [NSETS][NW];
  int          m_rr    [NSETS];
  logic [LW-1:0] backing [logic [31:0]];
  int m_hits, m_misses, m_wbs;
  logic [LW-1:0] line_l;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < BS; i++) l[i*DW +: DW] = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endtask

  task automatic predict(input logic [31:0] addr, input bit rd, input logic [LW-1:0] wdata,
                         output bit hit, output bit wb, output logic [31:0] wb_addr,
                         output logic [LW-1:0] wb_data, output bit fill,
                         output logic [31:0] line_addr, output logic [LW-1:0] rdata);
    int set, way;
    bit replaced;
    logic [31:0] tag;
    set = int'((addr >> OFFW) % NSETS);
    tag = addr >> (OFFW + IDXW);
    line_addr = addr - (addr % BS);
    way = -1;
    wb = 0; fill = 0; wb_addr = '0; wb_data = '0; rdata = '0;
    for (int w = 0; w < NW; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
    if (way >= 0) begin
      hit = 1; m_hits++;
      if (rd) rdata = m_data[set][way];
      else begin
        m_data[set][way] = wdata;
        m_dirty[set][way] = 1;
      end
    end else begin
      hit = 0; m_misses++;
      for (int w = NW - 1; w >= 0; w--)
        if (!m_valid[set][w]) way = w;
      replaced = (way < 0);
      if (replaced) way = m_rr[set];
      if (replaced && m_dirty[set][way]) begin
        wb = 1; m_wbs++;
        wb_addr = (m_tag[set][way] << (OFFW + IDXW)) | (32'(set) << OFFW);
        wb_data = m_data[set][way];
        backing[wb_addr] = wb_data;
      end
      if (rd) begin
        fill = 1;
        if (!backing.exists(line_addr)) backing[line_addr] = rand_line();
        rdata = backing[line_addr];
        m_data[set][way] = rdata;
        m_dirty[set][way] = 0;
      end else begin
        m_data[set][way] = wdata;
        m_dirty[set][way] = 1;
      end
      m_valid[set][way] = 1;
      m_tag[set][way] = tag;
      if (replaced) m_rr[set] = (m_rr[set] + 1) % NW;
    end
  endtask

  // One L1 transaction with the bench acting as main memory; starts and ends on a negedge.
  task automatic do_txn(input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [LW-1:0] wdata, input string name);
    bit e_hit, e_wb, e_fill, wb_seen, fill_seen, wb_resp, fill_resp, done;
    logic [31:0] e_wb_addr, e_line;
    logic [LW-1:0] e_wb_data, e_rdata;
    int cyc, delay;
    predict(addr, rd, wdata, e_hit, e_wb, e_wb_addr, e_wb_data, e_fill, e_line, e_rdata);
    bus.l1_addr = addr; bus.l1_read = rd; bus.l1_write = wr; bus.l1_data_in = wdata;
    cyc = 0; done = 0; wb_seen = 0; fill_seen = 0; wb_resp = 0; fill_resp = 0;
    delay = $urandom_range(0, 3);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_ready) bus.mem_ready = 1'b0;
      if (bus.l1_ready) begin
        done = 1;
      end else if (bus.mem_write && !wb_resp) begin
        if (!wb_seen) begin
          wb_seen = 1;
          checks++;
          if (bus.mem_addr !== e_wb_addr) begin
            failures++;
            $display("[TB] FAIL %s wb_addr actual=%h required=%h", name, bus.mem_addr, e_wb_addr);
          end
          checks++;
          if (bus.mem_data_out !== e_wb_data) begin
            failures++;
            $display("[TB] FAIL %s wb_data actual=%h required=%h", name, bus.mem_data_out, e_wb_data);
          end
        end
        if (delay == 0) begin
          bus.mem_ready = 1'b1; wb_resp = 1; delay = $urandom_range(0, 3);
        end else delay--;
      end else if (bus.mem_read && !fill_resp) begin
        if (!fill_seen) begin
          fill_seen = 1;
          checks++;
          if (bus.mem_addr !== e_line) begin
            failures++;
            $display("[TB] FAIL %s fill_addr actual=%h required=%h", name, bus.mem_addr, e_line);
          end
        end
        if (delay == 0) begin
          bus.mem_ready = 1'b1; bus.mem_data_in = e_rdata; fill_resp = 1;
        end else delay--;
      end
    end
    bus.l1_read = 1'b0; bus.l1_write = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL %s timeout actual=no_ready required=ready", name);
      return;
    end
    checks++;
    if (bus.l1_hit !== e_hit) begin
      failures++;
      $display("[TB] FAIL %s hit actual=%b required=%b", name, bus.l1_hit, e_hit);
    end
    if (rd) begin
      checks++;
      if (bus.l1_data_out !== e_rdata) begin
        failures++;
        $display("[TB] FAIL %s rdata actual=%h required=%h", name, bus.l1_data_out, e_rdata);
      end
    end
    checks++;
    if (wb_seen !== e_wb || fill_seen !== e_fill) begin
      failures++;
      $display("[TB] FAIL %s mem_ops actual=wb%0b/fill%0b required=wb%0b/fill%0b",
               name, wb_seen, fill_seen, e_wb, e_fill);
    end
    if (!e_wb && !e_fill) begin
      checks++;
      if (cyc != 2) begin
        failures++;
        $display("[TB] FAIL %s latency actual=%0d required=2", name, cyc);
      end
    end
    checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s mem_idle actual=%b%b required=00", name, bus.mem_read, bus.mem_write);
    end
    @(negedge clk);
    checks++;
    if (bus.l1_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s ready_pulse actual=%b required=0", name, bus.l1_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.l1_addr = '0; bus.l1_data_in = '0; bus.l1_read = 1'b0; bus.l1_write = 1'b0;
    bus.mem_data_in = '0; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.l1_ready, bus.l1_hit, bus.mem_read, bus.mem_write} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes actual=%b required=0000",
               {bus.l1_ready, bus.l1_hit, bus.mem_read, bus.mem_write});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.l1_data_out !== '0 || bus.mem_data_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_buses actual=%h required=0", bus.mem_addr);
    end
`ifdef L2_PERF_CNT_EN
    checks++;
    if ({hit_cnt, miss_cnt, wb_cnt} !== 96'b0) begin
      failures++;
      $display("[TB] FAIL reset_counters actual=%0d/%0d/%0d required=0/0/0", hit_cnt, miss_cnt, wb_cnt);
    end
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_read_miss_fill();
    do_txn(32'h100, 1, 0, rand_line(), "read_miss_0x100");
    line_l = backing[32'h100];
  endtask

  task automatic test_read_hit();
    do_txn(32'h105, 1, 0, rand_line(), "read_hit_0x105");
    checks++;
    if (bus.l1_data_out !== line_l) begin
      failures++;
      $display("[TB] FAIL hit_line_L actual=%h required=%h", bus.l1_data_out, line_l);
    end
  endtask

  task automatic test_write_miss();
    do_txn(32'h200, 0, 1, rand_line(), "write_miss_0x200");
    do_txn(32'h200, 1, 0, rand_line(), "read_after_write_0x200");
  endtask

  task automatic test_eviction();
    do_txn(32'h3000, 0, 1, rand_line(), "evict_dirty_first");
    do_txn(32'h3400, 1, 0, rand_line(), "evict_fill2");
    do_txn(32'h3800, 1, 0, rand_line(), "evict_fill3");
    do_txn(32'h3C00, 1, 0, rand_line(), "evict_fill4");
    do_txn(32'h4000, 1, 0, rand_line(), "evict_wb_then_fill");
    do_txn(32'h4400, 1, 0, rand_line(), "evict_rr_next");
    do_txn(32'h3800, 1, 0, rand_line(), "evict_survivor_hit");
    do_txn(32'h3000, 1, 0, rand_line(), "evict_refetch_dirty");
  endtask

  task automatic test_both_high();
    do_txn(32'h108, 1, 1, rand_line(), "both_high_as_read");
    do_txn(32'h100, 1, 0, rand_line(), "both_high_line_unchanged");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    int r;
    for (int i = 0; i < 80; i++) begin
      a = (32'($urandom_range(0, 5)) << (OFFW + IDXW)) | (32'($urandom_range(2, 3)) << OFFW)
          | 32'($urandom_range(0, BS - 1));
      r = $urandom_range(0, 99);
      if (r < 60)      do_txn(a, 1, 0, rand_line(), "rand_read");
      else if (r < 95) do_txn(a, 0, 1, rand_line(), "rand_write");
      else             do_txn(a, 1, 1, rand_line(), "rand_both");
    end
  endtask

  task automatic test_reset_mid_fill();
    int cyc;
    bus.l1_addr = 32'h900; bus.l1_read = 1'b1; bus.l1_write = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.mem_read && cyc < 20);
    checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h900) begin
      failures++;
      $display("[TB] FAIL midreset_fill_req actual=%b/%h required=1/00000900", bus.mem_read, bus.mem_addr);
    end
    rst_n = 1'b0;
    bus.l1_read = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b0 || bus.l1_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_drop actual=%b%b required=00", bus.mem_read, bus.l1_ready);
    end
    rst_n = 1'b1;
    model_reset();
    do_txn(32'h100, 1, 0, rand_line(), "midreset_0x100_misses");
  endtask

  task automatic test_perf_counters();
`ifdef L2_PERF_CNT_EN
    checks++;
    if (hit_cnt !== 32'(m_hits)) begin
      failures++;
      $display("[TB] FAIL hit_cnt actual=%0d required=%0d", hit_cnt, m_hits);
    end
    checks++;
    if (miss_cnt !== 32'(m_misses)) begin
      failures++;
      $display("[TB] FAIL miss_cnt actual=%0d required=%0d", miss_cnt, m_misses);
    end
    checks++;
    if (wb_cnt !== 32'(m_wbs)) begin
      failures++;
      $display("[TB] FAIL wb_cnt actual=%0d required=%0d", wb_cnt, m_wbs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read_miss_fill();
    test_read_hit();
    test_write_miss();
    test_eviction();
    test_both_high();
    test_perf_counters();
    test_back_to_back();
    test_perf_counters();
    test_reset_mid_fill();
    test_perf_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
